// File: rtl/lfsr_pkg.sv
// Shared types and default polynomial constants for the LFSR word generator.
package lfsr_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fsm_e;

  typedef enum logic {
    MODE_FIB = 1'b0,
    MODE_GAL = 1'b1
  } mode_e;

  // Fibonacci tap masks: bit k-1 set for each x^k term (x^W included).
  localparam logic [7:0]  FIB_TAPS_W8  = 8'hB8;         // x^8+x^6+x^5+x^4+1
  localparam logic [9:0]  FIB_TAPS_W10 = 10'h240;       // x^10+x^7+1
  localparam logic [15:0] FIB_TAPS_W16 = 16'hD008;      // x^16+x^15+x^13+x^4+1
  localparam logic [31:0] FIB_TAPS_W32 = 32'h8020_0003; // x^32+x^22+x^2+x+1

  // Galois masks: low-order terms of the polynomial (x^W implied by the MSB).
  localparam logic [7:0]  GAL_MASK_W8  = 8'h1D;         // x^8+x^4+x^3+x^2+1
  localparam logic [9:0]  GAL_MASK_W10 = 10'h009;       // x^10+x^3+1
  localparam logic [15:0] GAL_MASK_W16 = 16'h002D;      // x^16+x^5+x^3+x^2+1
  localparam logic [31:0] GAL_MASK_W32 = 32'h0000_00AF; // x^32+x^7+x^5+x^3+x^2+x+1

  function automatic logic [31:0] default_fib_taps(input int unsigned w);
    case (w)
      32'd8:   return 32'(FIB_TAPS_W8);
      32'd16:  return 32'(FIB_TAPS_W16);
      32'd32:  return FIB_TAPS_W32;
      default: return 32'(FIB_TAPS_W10);
    endcase
  endfunction

  function automatic logic [31:0] default_gal_mask(input int unsigned w);
    case (w)
      32'd8:   return 32'(GAL_MASK_W8);
      32'd16:  return 32'(GAL_MASK_W16);
      32'd32:  return GAL_MASK_W32;
      default: return 32'(GAL_MASK_W10);
    endcase
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single step of a Fibonacci or Galois LFSR.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] state_i,
  input  mode_e        mode_i,
  input  logic [W-1:0] fib_taps_i,
  input  logic [W-1:0] gal_mask_i,
  output logic [W-1:0] next_state_c_o,
  output logic         out_bit_c_o
);

  logic fb_c;

  assign fb_c = ^(state_i & fib_taps_i);

  always_comb begin
    next_state_c_o = '0;
    out_bit_c_o    = 1'b0;
    if (mode_i == MODE_GAL) begin
      // Output is the bit shifted out; feedback folds in when it was a 1.
      out_bit_c_o    = state_i[W-1];
      next_state_c_o = {state_i[W-2:0], 1'b0} ^ (state_i[W-1] ? gal_mask_i : '0);
    end else begin
      out_bit_c_o    = fb_c;
      next_state_c_o = {state_i[W-2:0], fb_c};
    end
  end

endmodule

// File: rtl/lfsr_word_gen.sv
// Parametrised LFSR bit generator packing OUT_W bits per valid/ready word.
// Optional period checker enabled by defining LFSR_PERIOD_CHK_EN.
module lfsr_word_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned    W            = 10,
  parameter int unsigned    OUT_W        = 8,
  parameter logic [W-1:0]   FIB_TAPS     = W'(default_fib_taps(W)),
  parameter logic [W-1:0]   GAL_MASK     = W'(default_gal_mask(W)),
  parameter logic [W-1:0]   SEED_DEFAULT = W'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [W-1:0]     seed,
  input  logic             mode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [W-1:0]     state_q,
  output logic             lockup_flag,
  output logic             period_done,
  output logic [W-1:0]     period_len
);

  localparam int unsigned CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  fsm_e             fsm_q, fsm_d;
  mode_e            mode_q, mode_d;
  logic [W-1:0]     state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             lockup_q, lockup_d;

  logic [W-1:0]     step_next_c;
  logic             step_bit_c;
  logic             zero_state_c;
  logic             seed_zero_c;
  logic [W-1:0]     seed_eff_c;

`ifdef LFSR_PERIOD_CHK_EN
  logic [W-1:0]     ref_q, ref_d;
  logic [W-1:0]     cnt_q, cnt_d;
  logic [W-1:0]     period_len_q, period_len_d;
  logic             period_done_q, period_done_d;
`endif

  lfsr_step #(
    .W (W)
  ) u_step (
    .state_i        (state_q),
    .mode_i         (mode_q),
    .fib_taps_i     (FIB_TAPS),
    .gal_mask_i     (GAL_MASK),
    .next_state_c_o (step_next_c),
    .out_bit_c_o    (step_bit_c)
  );

  assign zero_state_c = (state_q == '0);
  assign seed_zero_c  = (seed == '0);
  assign seed_eff_c   = seed_zero_c ? SEED_DEFAULT : seed;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= FILL;
      mode_q      <= MODE_FIB;
      state_q     <= SEED_DEFAULT;
      bit_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      lockup_q    <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      mode_q      <= mode_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      lockup_q    <= lockup_d;
    end
  end

`ifdef LFSR_PERIOD_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q         <= SEED_DEFAULT;
      cnt_q         <= '0;
      period_len_q  <= '0;
      period_done_q <= 1'b0;
    end else begin
      ref_q         <= ref_d;
      cnt_q         <= cnt_d;
      period_len_q  <= period_len_d;
      period_done_q <= period_done_d;
    end
  end
`endif

  // Next-state: seed load dominates, then lock-up recovery, then FILL/HOLD.
  always_comb begin
    fsm_d       = fsm_q;
    mode_d      = mode_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    lockup_d    = lockup_q;
`ifdef LFSR_PERIOD_CHK_EN
    ref_d         = ref_q;
    cnt_d         = cnt_q;
    period_len_d  = period_len_q;
    period_done_d = 1'b0;
`endif

    if (seed_load) begin
      state_d     = seed_eff_c;
      mode_d      = mode_e'(mode);
      lockup_d    = seed_zero_c;
      bit_cnt_d   = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      fsm_d       = FILL;
`ifdef LFSR_PERIOD_CHK_EN
      ref_d = seed_eff_c;
      cnt_d = '0;
`endif
    end else begin
      if (zero_state_c) begin
        state_d  = SEED_DEFAULT;
        lockup_d = 1'b1;
`ifdef LFSR_PERIOD_CHK_EN
        ref_d = SEED_DEFAULT;
        cnt_d = '0;
`endif
      end

      case (fsm_q)
        FILL: begin
          // A recovery cycle replaces the step, so no bit is emitted.
          if (en && !zero_state_c) begin
            state_d                = step_next_c;
            out_data_d[bit_cnt_q]  = step_bit_c;
            if (bit_cnt_q == CNT_W'(OUT_W - 1)) begin
              bit_cnt_d   = '0;
              out_valid_d = 1'b1;
              fsm_d       = HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
`ifdef LFSR_PERIOD_CHK_EN
            if (step_next_c == ref_q) begin
              period_done_d = 1'b1;
              period_len_d  = cnt_q + W'(1);
              cnt_d         = '0;
            end else begin
              cnt_d = cnt_q + W'(1);
            end
`endif
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            fsm_d       = FILL;
          end
        end
        default: fsm_d = FILL;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign lockup_flag = lockup_q;

`ifdef LFSR_PERIOD_CHK_EN
  assign period_done = period_done_q;
  assign period_len  = period_len_q;
`else
  assign period_done = 1'b0;
  assign period_len  = '0;
`endif

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Self-checking bench for lfsr_word_gen (W=10, OUT_W=8) against a behavioural model.
module tb_lfsr_word_gen;

  localparam int unsigned W     = 10;
  localparam int unsigned OUT_W = 8;
  localparam int          TAPS  = 'h240;
  localparam int          GMASK = 'h009;
  localparam int          SDEF  = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             seed_load = 1'b0;
  logic [W-1:0]     seed = '0;
  logic             mode = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic [W-1:0]     state_q;
  logic             lockup_flag;
  logic             period_done;
  logic [W-1:0]     period_len;

  lfsr_word_gen #(
    .W            (W),
    .OUT_W        (OUT_W),
    .FIB_TAPS     (10'h240),
    .GAL_MASK     (10'h009),
    .SEED_DEFAULT (10'h001)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .seed_load   (seed_load),
    .seed        (seed),
    .mode        (mode),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .state_q     (state_q),
    .lockup_flag (lockup_flag),
    .period_done (period_done),
    .period_len  (period_len)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer arithmetic on the polynomial rules.
  int  m_state, m_ref, m_cnt, m_plen, m_n;
  bit  m_gal, m_valid, m_lock, m_pdone;
  logic [OUT_W-1:0] m_data;

  function automatic void model_step(input int s, input bit gal, output int ns, output int b);
    if (!gal) begin
      b  = $countones(s & TAPS) % 2;
      ns = ((s * 2) % 1024) + b;
    end else begin
      b  = (s >= 512) ? 1 : 0;
      ns = ((s * 2) % 1024) ^ (b != 0 ? GMASK : 0);
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    int ns, b;
    bit rec;
    if (rst) begin
      m_state = SDEF; m_gal = 0; m_valid = 0; m_data = '0; m_n = 0;
      m_lock = 0; m_ref = SDEF; m_cnt = 0; m_pdone = 0; m_plen = 0;
    end else begin
      m_pdone = 0;
      rec     = 0;
      if (seed_load) begin
        m_state = (seed == 0) ? SDEF : int'(seed);
        m_lock  = (seed == 0);
        m_gal   = mode;
        m_valid = 0; m_data = '0; m_n = 0;
        m_ref   = m_state; m_cnt = 0;
      end else begin
        if (m_state == 0) begin
          m_state = SDEF; m_lock = 1; m_ref = SDEF; m_cnt = 0; rec = 1;
        end
        if (!m_valid) begin
          if (en && !rec) begin
            model_step(m_state, m_gal, ns, b);
            m_state   = ns;
            m_data[m_n] = b[0];
            m_n++;
            if (m_n == OUT_W) begin
              m_n = 0; m_valid = 1;
            end
            m_cnt++;
            if (m_state == m_ref) begin
              m_pdone = 1; m_plen = m_cnt; m_cnt = 0;
            end
          end
        end else if (out_ready) begin
          m_valid = 0;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_data);
      chk("state_q", state_q, m_state);
      chk("lockup_flag", lockup_flag, m_lock);
`ifdef LFSR_PERIOD_CHK_EN
      chk("period_done", period_done, m_pdone);
      chk("period_len", period_len, m_plen);
`else
      chk("period_done_tied", period_done, 0);
      chk("period_len_tied", period_len, 0);
`endif
    end
  end

  task automatic load(input logic [W-1:0] s, input logic md);
    seed = s; mode = md; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  initial begin
    logic [W-1:0] fib_exp [8] = '{10'h002, 10'h004, 10'h008, 10'h010,
                                  10'h020, 10'h040, 10'h081, 10'h102};
    bit saw;
    int t;

    repeat (3) @(negedge clk);
    chk("rst_state", state_q, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_lock", lockup_flag, 0);
    chk("rst_pdone", period_done, 0);
    chk("rst_plen", period_len, 0);
    rst = 1'b0; cmp_on = 1'b1;
    @(negedge clk);

    // Fibonacci sequence from seed 1.
    en = 1'b1; out_ready = 1'b1;
    load(10'h001, 1'b0);
    chk("fib_load_state", state_q, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fib_state", state_q, fib_exp[k]);
      if (k == 6) chk("fib_valid_early", out_valid, 0);
    end
    chk("fib_word_valid", out_valid, 1);
    chk("fib_word_data", out_data, 8'h40);

    // Galois: step 9 reaches 0x200 (transfer cycle between), step 10 wraps.
    load(10'h001, 1'b1);
    repeat (10) @(negedge clk);
    chk("gal_step9", state_q, 10'h200);
    @(negedge clk);
    chk("gal_step10", state_q, 10'h009);
    chk("gal_step10_bit", out_data, 8'h02);

    // Stall in HOLD for 20 cycles, then a single transfer.
    out_ready = 1'b0;
    load(10'h3A7, 1'b0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("stall_valid_rise", out_valid, 1);
    repeat (20) begin
      @(negedge clk);
      chk("stall_valid_held", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_transfer", out_valid, 0);
    repeat (3) @(negedge clk);

    // Zero seed recovers to default and flags; non-zero load clears.
    load(10'h000, 1'b1);
    chk("zero_seed_state", state_q, 1);
    chk("zero_seed_lock", lockup_flag, 1);
    load(10'h155, 1'b0);
    chk("seed155_lock", lockup_flag, 0);
    chk("seed155_state", state_q, 10'h155);

    // Mid-word reload discards the partial word; en low pauses.
    en = 1'b1; out_ready = 1'b1;
    load(10'h3FF, 1'b1);
    repeat (5) @(negedge clk);
    chk("midword_partial", out_data[0], 1);
    load(10'h2A5, 1'b0);
    chk("midword_data", out_data, 0);
    chk("midword_valid", out_valid, 0);
    chk("midword_state", state_q, 10'h2A5);
    en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("pause_state", state_q, 10'h2A5);
    end
    en = 1'b1;
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-word with lockup_flag set.
    load(10'h000, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", state_q, 1);
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_lock", lockup_flag, 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en        = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        seed_load = 1'b1;
        seed      = ($urandom_range(0, 9) == 0) ? 10'h000 : 10'($urandom_range(1, 1023));
        mode      = 1'($urandom_range(0, 1));
      end else begin
        seed_load = 1'b0;
      end
    end
    @(negedge clk);
    seed_load = 1'b0;

    // Full period of the default Fibonacci polynomial.
    en = 1'b1; out_ready = 1'b1;
    load(10'h001, 1'b0);
    saw = 1'b0;
    for (int i = 0; i < 1400; i++) begin
      @(negedge clk);
`ifdef LFSR_PERIOD_CHK_EN
      if (period_done && !saw) begin
        saw = 1'b1;
        chk("period_len_1023", period_len, 1023);
      end
`endif
    end
`ifdef LFSR_PERIOD_CHK_EN
    chk("period_seen", saw, 1);
`endif

    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
